// File: rtl/trng_if.sv
// Entropy-front-end pin bundle between the conditioner (master) and the SoC
// wrapper / analog source side (slave).
interface trng_if #(
  parameter int FIFO_DEPTH = 32
) ();
  logic                          raw_bit;
  logic                          osc_en;
  logic                          trng_req;
  logic                          trng_bit;
  logic                          trng_valid;
  logic                          health_fail;
  logic [$clog2(FIFO_DEPTH):0]   fill_level;

  modport master (
    input  raw_bit, trng_req,
    output osc_en, trng_bit, trng_valid, health_fail, fill_level
  );

  modport slave (
    output raw_bit, trng_req,
    input  osc_en, trng_bit, trng_valid, health_fail, fill_level
  );
endinterface

// File: rtl/trng_conditioner.sv
// Raw oscillator bit -> sync -> decimate -> von Neumann debias + repetition
// count health test -> conditioned-bit FIFO popped by the SoC.
//
// state | meaning
// EMPTY | no sample held, next strobe opens a pair
// HALF  | first sample of a pair held in stored_q
module trng_conditioner #(
  parameter int SAMPLE_DIV = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int RCT_CUTOFF = 32
) (
  input  logic   clk,
  input  logic   reset,
  trng_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = PW + 1;
  localparam int DW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  typedef enum logic {EMPTY, HALF} pair_t;

  pair_t             pair_q, pair_d;
  logic              stored_q, stored_d;
  logic              push_q, push_d;
  logic              push_bit_q, push_bit_d;

  logic [1:0]        sync_q;
  logic [DW-1:0]     div_q;
  logic              osc_en_q;
  logic [RW-1:0]     rct_q;
  logic              prev_q;
  logic              fail_q;
  logic [FIFO_DEPTH-1:0] mem_q;
  logic [PW-1:0]     rd_q, wr_q;
  logic [FW-1:0]     fill_q;

  logic              sample, strobe, fail_now, valid, pop, push_ok, full;
  logic [RW-1:0]     rct_next;

  assign sample   = sync_q[1];
  assign strobe   = osc_en_q && (div_q == DW'(SAMPLE_DIV - 1));
  assign full     = (fill_q == FW'(FIFO_DEPTH));
  assign valid    = (fill_q != '0) && !fail_q;
  assign pop      = bus.trng_req && valid;
  assign rct_next = ((rct_q != '0) && (sample == prev_q)) ? rct_q + RW'(1) : RW'(1);
  assign fail_now = strobe && (rct_next == RW'(RCT_CUTOFF));
  // A failing cycle drops the pending push along with flushing the FIFO.
  assign push_ok  = push_q && !fail_now && !full;

  always_ff @(posedge clk) begin
    if (reset) begin
      pair_q     <= EMPTY;
      stored_q   <= 1'b0;
      push_q     <= 1'b0;
      push_bit_q <= 1'b0;
    end else begin
      pair_q     <= pair_d;
      stored_q   <= stored_d;
      push_q     <= push_d;
      push_bit_q <= push_bit_d;
    end
  end

  always_comb begin
    pair_d     = pair_q;
    stored_d   = stored_q;
    push_d     = 1'b0;
    push_bit_d = push_bit_q;
    if (strobe) begin
      case (pair_q)
        EMPTY: begin
          stored_d = sample;
          pair_d   = HALF;
        end
        HALF: begin
          push_d     = (stored_q != sample);
          push_bit_d = stored_q;
          pair_d     = EMPTY;
        end
        default: pair_d = EMPTY;
      endcase
    end
    if (fail_now) begin
      pair_d = EMPTY;
      push_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      div_q    <= '0;
      osc_en_q <= 1'b0;
      rct_q    <= '0;
      prev_q   <= 1'b0;
      fail_q   <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      fill_q   <= '0;
    end else begin
      sync_q   <= {sync_q[0], bus.raw_bit};
      osc_en_q <= !fail_q && !fail_now && !full;
      if (osc_en_q)
        div_q <= (div_q == DW'(SAMPLE_DIV - 1)) ? '0 : div_q + DW'(1);
      if (strobe) begin
        rct_q  <= rct_next;
        prev_q <= sample;
      end
      if (push_ok) begin
        mem_q[wr_q] <= push_bit_q;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop)
        rd_q <= rd_q + PW'(1);
      case ({push_ok, pop})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
      if (fail_now) begin
        fail_q <= 1'b1;
        rd_q   <= '0;
        wr_q   <= '0;
        fill_q <= '0;
      end
    end
  end

  assign bus.osc_en      = osc_en_q;
  assign bus.trng_valid  = valid;
  assign bus.trng_bit    = valid & mem_q[rd_q];
  assign bus.health_fail = fail_q;
  assign bus.fill_level  = fill_q;
endmodule

// File: tb/tb_trng_conditioner.sv
// Bench for trng_conditioner: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic checked every cycle against a queue model.
module tb_trng_conditioner;
  localparam int SD    = 16;
  localparam int DEPTH = 32;
  localparam int CUT   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw = 1'b0;
  logic req = 1'b0;

  logic [31:0] pat = '0;
  int n_tick = 0;
  int n_tests = 0;
  int n_fail = 0;

  trng_if #(.FIFO_DEPTH(DEPTH)) bus ();
  assign bus.raw_bit  = raw;
  assign bus.trng_req = req;

  trng_conditioner #(.SAMPLE_DIV(SD), .FIFO_DEPTH(DEPTH), .RCT_CUTOFF(CUT)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: sampler/pair/RCT state as plain integers, FIFO as a queue.
  bit m_sync0, m_sync1, m_osc, m_prev, m_fail;
  int m_div, m_slot, m_pend, m_rct;
  bit mq[$];

  task automatic model_step(input bit rs, input bit rw, input bit rq);
    int  sz, rct_new, new_pend;
    bit  pop, strobe, smp, trip, old_osc;
    sz      = mq.size();
    pop     = rq && (sz > 0) && !m_fail;
    strobe  = m_osc && (m_div == SD - 1);
    smp     = m_sync1;
    trip    = 1'b0;
    rct_new = m_rct;
    if (strobe) begin
      rct_new = (m_rct > 0 && smp == m_prev) ? m_rct + 1 : 1;
      trip    = (rct_new == CUT);
    end
    if (rs) begin
      m_sync0 = 0; m_sync1 = 0; m_osc = 0; m_prev = 0; m_fail = 0;
      m_div = 0; m_slot = -1; m_pend = -1; m_rct = 0;
      mq.delete();
    end else begin
      old_osc = m_osc;
      m_osc   = !m_fail && !trip && (sz != DEPTH);
      if (old_osc) m_div = (m_div + 1) % SD;
      m_sync1 = m_sync0;
      m_sync0 = rw;
      if (pop) void'(mq.pop_front());
      if (m_pend >= 0 && !trip && sz < DEPTH) mq.push_back(m_pend == 1);
      new_pend = -1;
      if (strobe) begin
        m_rct  = rct_new;
        m_prev = smp;
        if (m_slot < 0) m_slot = smp;
        else begin
          if (m_slot != int'(smp)) new_pend = m_slot;
          m_slot = -1;
        end
      end
      m_pend = new_pend;
      if (trip) begin
        m_fail = 1;
        mq.delete();
        m_slot = -1;
        m_pend = -1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input bit rs, input bit rq);
    logic [31:0] act, exp;
    bit mv, mb;
    if (rs) n_tick = 0; else n_tick++;
    rst = rs;
    req = rq;
    raw = pat[(n_tick / SD) % 32];
    @(posedge clk);
    model_step(rs, raw, rq);
    @(negedge clk);
    mv  = (mq.size() > 0) && !m_fail;
    mb  = mv ? mq[0] : 1'b0;
    act = {22'd0, bus.osc_en, bus.trng_valid, bus.trng_bit, bus.health_fail, bus.fill_level};
    exp = {22'd0, m_osc, mv, mb, m_fail, 6'(mq.size())};
    check($sformatf("model t%0d {osc,vld,bit,fail,fill}", n_tick), act, exp);
  endtask

  task automatic check_outs(input string tag, input int fill, input bit osc,
                            input bit vld, input bit tb_bit, input bit fl);
    check({tag, "_fill"},  32'(bus.fill_level),  32'(fill));
    check({tag, "_osc"},   32'(bus.osc_en),      32'(osc));
    check({tag, "_valid"}, 32'(bus.trng_valid),  32'(vld));
    check({tag, "_bit"},   32'(bus.trng_bit),    32'(tb_bit));
    check({tag, "_fail"},  32'(bus.health_fail), 32'(fl));
  endtask

  typedef struct {
    bit          rs;
    logic [31:0] pat;
    bit          rq;
    int          cyc;
    int          fill;
    bit          osc;
    bit          vld;
    bit          tbit;
    bit          fl;
  } vec_t;

  vec_t vecs[16];
  bit   exp5[5] = '{0, 1, 1, 0, 0};

  initial begin
    // alternating samples fill with 0s; stuck-1 trips RCT; 11,00,10 -> one 1;
    // 31-long run stays healthy; reset mid-run; first-bit latency after reset
    vecs[0]  = '{1, 32'hAAAA_AAAA, 0, 0,    0,  0, 0, 0, 0};
    vecs[1]  = '{0, 32'hAAAA_AAAA, 0, 1,    0,  1, 0, 0, 0};
    vecs[2]  = '{0, 32'hAAAA_AAAA, 0, 1099, 32, 0, 1, 0, 0};
    vecs[3]  = '{1, 32'hFFFF_FFFF, 0, 0,    0,  0, 0, 0, 0};
    vecs[4]  = '{0, 32'hFFFF_FFFF, 0, 512,  0,  1, 0, 0, 0};
    vecs[5]  = '{0, 32'hFFFF_FFFF, 0, 1,    0,  0, 0, 0, 1};
    vecs[6]  = '{0, 32'hFFFF_FFFF, 1, 20,   0,  0, 0, 0, 1};
    vecs[7]  = '{1, 32'h0000_0013, 0, 0,    0,  0, 0, 0, 0};
    vecs[8]  = '{0, 32'h0000_0013, 0, 100,  1,  1, 1, 1, 0};
    vecs[9]  = '{1, 32'h0000_0001, 0, 0,    0,  0, 0, 0, 0};
    vecs[10] = '{0, 32'h0000_0001, 0, 1600, 4,  1, 1, 1, 0};
    vecs[11] = '{1, 32'hAAAA_AAAA, 0, 0,    0,  0, 0, 0, 0};
    vecs[12] = '{0, 32'hAAAA_AAAA, 0, 660,  20, 1, 1, 0, 0};
    vecs[13] = '{1, 32'hAAAA_AAAA, 0, 0,    0,  0, 0, 0, 0};
    vecs[14] = '{0, 32'hAAAA_AAAA, 0, 33,   0,  1, 0, 0, 0};
    vecs[15] = '{0, 32'hAAAA_AAAA, 0, 1,    1,  1, 1, 0, 0};

    for (int v = 0; v < 16; v++) begin
      pat = vecs[v].pat;
      if (vecs[v].rs) tick(1'b1, 1'b0);
      repeat (vecs[v].cyc) tick(1'b0, vecs[v].rq);
      check_outs($sformatf("vec%0d", v), vecs[v].fill, vecs[v].osc,
                 vecs[v].vld, vecs[v].tbit, vecs[v].fl);
    end

    // Drain a full FIFO: osc_en returns one cycle after the first pop.
    pat = 32'hAAAA_AAAA;
    tick(1'b1, 1'b0);
    repeat (1100) tick(1'b0, 1'b0);
    check_outs("drain_full", 32, 0, 1, 0, 0);
    pat = 32'h0;
    tick(1'b0, 1'b1);
    check("drain_pop1_fill", 32'(bus.fill_level), 32'd31);
    check("drain_pop1_osc",  32'(bus.osc_en), 32'd0);
    tick(1'b0, 1'b1);
    check("drain_pop2_osc",  32'(bus.osc_en), 32'd1);
    repeat (29) tick(1'b0, 1'b1);
    check_outs("drain_pop31", 1, 1, 1, 0, 0);
    tick(1'b0, 1'b1);
    check_outs("drain_pop32", 0, 1, 0, 0, 0);

    // Push and pop on the same edge at fill 5, then order of the remainder.
    pat = 32'h0000_1A59;
    tick(1'b1, 1'b0);
    repeat (193) tick(1'b0, 1'b0);
    check_outs("pp_pre", 5, 1, 1, 1, 0);
    tick(1'b0, 1'b1);
    check("pp_same_fill", 32'(bus.fill_level), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("pp_order%0d", i), 32'(bus.trng_bit), 32'(exp5[i]));
      tick(1'b0, 1'b1);
    end
    check("pp_empty_fill", 32'(bus.fill_level), 32'd0);

    // Randomized traffic; the model comparison inside tick() does the checking.
    for (int s = 0; s < 4; s++) begin
      pat = (s == 3) ? 32'h0 : $urandom;
      tick(1'b1, 1'b0);
      for (int i = 0; i < 1000; i++) begin
        if (s != 3 && $urandom_range(0, 99) == 0) pat = $urandom & (s == 2 ? $urandom : 32'hFFFF_FFFF);
        tick($urandom_range(0, 599) == 0, $urandom_range(0, 3 + 8 * (s % 2)) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
